// File: rtl/core_mul_pkg.sv
// Shared types and constants for the iterative RV64M multiplier.
// Operation encoding follows the issue-stage funct3 subset for the multiply group.
package core_mul_pkg;

   localparam int MUL_XLEN  = 64;
   localparam int MUL_CNT_W = $clog2(MUL_XLEN);

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'd0,
      MUL_OP_MULH   = 2'd1,
      MUL_OP_MULHSU = 2'd2,
      MUL_OP_MULHU  = 2'd3
   } mul_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } mul_state_e;

endpackage

// File: rtl/core_64bit_adder.sv
// Plain combinational adder shared by the execute-stage datapaths.
// Width is a parameter so the multiplier can widen it by one bit for the carry.
module core_64bit_adder #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/core_iter_multiplier.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW with a fixed
// XLEN+1 cycle latency; signed forms multiply magnitudes and fix the sign at the end.
module core_iter_multiplier
   import core_mul_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_mul_valid,
   output logic             o_mul_ready,
   input  logic [1:0]       i_mul_op,
   input  logic             i_mul_word,
   input  logic [XLEN-1:0]  i_mul_srcA,
   input  logic [XLEN-1:0]  i_mul_srcB,
   input  logic [TAG_W-1:0] i_mul_tag,
   input  logic             i_mul_flush,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [XLEN-1:0]  o_res_data,
   output logic [TAG_W-1:0] o_res_tag
);

   localparam int CNT_W = (XLEN == MUL_XLEN) ? MUL_CNT_W : $clog2(XLEN);

   mul_state_e        state_q;
   mul_op_e           op_q;
   mul_op_e           req_op;
   logic              word_q;
   logic              neg_res_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   m_q;
   logic [XLEN-1:0]   p_hi_q;
   logic [XLEN-1:0]   p_lo_q;

   logic              req_word;
   logic              sign_a;
   logic              sign_b;
   logic              neg_a;
   logic              neg_b;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic [XLEN:0]     add_a;
   logic [XLEN:0]     add_b;
   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] p_fixed;
   logic [XLEN-1:0]   res_sel;

   assign o_mul_ready = (state_q == ST_IDLE) & ~i_mul_flush;

   // Operand conditioning at accept: the W form only exists for plain MUL, and
   // the most negative value keeps its magnitude as an unsigned 2^(XLEN-1).
   assign req_op   = mul_op_e'(i_mul_op);
   assign req_word = i_mul_word & (req_op == MUL_OP_MUL);
   assign sign_a   = ((req_op == MUL_OP_MULH) | (req_op == MUL_OP_MULHSU)) & ~req_word;
   assign sign_b   = (req_op == MUL_OP_MULH) & ~req_word;
   assign neg_a    = sign_a & i_mul_srcA[XLEN-1];
   assign neg_b    = sign_b & i_mul_srcB[XLEN-1];
   assign abs_a    = neg_a ? (~i_mul_srcA + XLEN'(1)) : i_mul_srcA;
   assign abs_b    = neg_b ? (~i_mul_srcB + XLEN'(1)) : i_mul_srcB;

   assign add_a = {1'b0, p_hi_q};
   assign add_b = p_lo_q[0] ? {1'b0, m_q} : '0;

   core_64bit_adder #(
      .WIDTH (XLEN + 1)
   ) u_adder (
      .a   (add_a),
      .b   (add_b),
      .sum (add_sum)
   );

   assign p_fixed = neg_res_q ? (~{p_hi_q, p_lo_q} + (2*XLEN)'(1)) : {p_hi_q, p_lo_q};

   always_comb begin
      res_sel = p_fixed[2*XLEN-1:XLEN];
      if (word_q) begin
         res_sel = {{(XLEN-32){p_fixed[31]}}, p_fixed[31:0]};
      end else if (op_q == MUL_OP_MUL) begin
         res_sel = p_fixed[XLEN-1:0];
      end
   end

   // Flush only resets control state; the result registers keep their last value
   // so that a reset is the only thing that zeroes them.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= MUL_OP_MUL;
         word_q      <= 1'b0;
         neg_res_q   <= 1'b0;
         cnt_q       <= '0;
         m_q         <= '0;
         p_hi_q      <= '0;
         p_lo_q      <= '0;
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_tag   <= '0;
      end else if (i_mul_flush) begin
         state_q     <= ST_IDLE;
         o_res_valid <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_mul_valid) begin
                  op_q      <= req_op;
                  word_q    <= req_word;
                  neg_res_q <= neg_a ^ neg_b;
                  m_q       <= abs_a;
                  p_lo_q    <= abs_b;
                  p_hi_q    <= '0;
                  cnt_q     <= '0;
                  o_res_tag <= i_mul_tag;
                  state_q   <= ST_CALC;
               end
            end
            ST_CALC: begin
               p_hi_q <= add_sum[XLEN:1];
               p_lo_q <= {add_sum[0], p_lo_q[XLEN-1:1]};
               cnt_q  <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) begin
                  state_q <= ST_SIGN;
               end
            end
            ST_SIGN: begin
               {p_hi_q, p_lo_q} <= p_fixed;
               o_res_data       <= res_sel;
               o_res_valid      <= 1'b1;
               state_q          <= ST_DONE;
            end
            ST_DONE: begin
               if (i_res_ready) begin
                  o_res_valid <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
